// File: rtl/uart_modport.sv
// Byte-wide bus-slave UART with a 16550-style register map, TX/RX FIFOs,
// programmable baud divisor, 5-8 bit framing with parity, and internal loopback.
module uart_modport #(
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_in,
    input  logic [2:0] addr_in,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    input  logic [3:0] sel_in,
    input  logic       stb_in,
    input  logic       cyc_in,
    input  logic       wr_enb_in,
    output logic       ack_out,
    output logic       int_out,
    input  logic       rx_in,
    output logic       tx_out
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] Full = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;
    typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop} rx_state_e;

    // Parity bit for the active word length; stick parity overrides the data.
    function automatic logic par_calc(input logic [7:0] d, input logic [1:0] wlen,
                                      input logic even, input logic stick);
        logic p;
        p = ^(d & (8'hFF >> (2'd3 - wlen)));
        if (stick) return ~even;
        return even ? p : ~p;
    endfunction

    logic [3:0] ier_q;
    logic [7:0] lcr_q, scr_q, dll_q, dlm_q, rbr_q, dout_q;
    logic [4:0] mcr_q;
    logic [1:0] trig_q;
    logic       oe_q, pe_q, fe_q, bi_q, thre_q, ack_q, tx_out_q;
    logic       unused_sel;
    assign unused_sel = ^sel_in[3:1];

    // Bus request decode; one access per ack, so a held strobe acks every other cycle.
    logic req, wr, rd, dlab, thr_wr, rbr_rd, fcr_wr, iir_rd, lsr_rd;
    assign req    = stb_in & cyc_in & sel_in[0] & ~ack_q;
    assign wr     = req & wr_enb_in;
    assign rd     = req & ~wr_enb_in;
    assign dlab   = lcr_q[7];
    assign thr_wr = wr && addr_in == 3'd0 && !dlab;
    assign rbr_rd = rd && addr_in == 3'd0 && !dlab;
    assign fcr_wr = wr && addr_in == 3'd2;
    assign iir_rd = rd && addr_in == 3'd2;
    assign lsr_rd = rd && addr_in == 3'd5;

    // Baud generator: one 16x tick every {DLM,DLL} clocks, halted when zero.
    logic [15:0] div, baud_cnt_q;
    logic        baud_tick;
    assign div       = {dlm_q, dll_q};
    assign baud_tick = (div != 16'd0) && (baud_cnt_q >= div - 16'd1);
    always_ff @(posedge clk) begin
        if (rst_in || baud_tick || div == 16'd0) baud_cnt_q <= '0;
        else                                    baud_cnt_q <= baud_cnt_q + 16'd1;
    end

    // TX FIFO
    logic [7:0]    tx_mem [FIFO_DEPTH];
    logic [PW-1:0] tx_wp_q, tx_rp_q;
    logic [CW-1:0] tx_cnt_q;
    logic          tx_push, tx_pop;
    assign tx_push = thr_wr && tx_cnt_q != Full;

    // TX FIFO storage
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp_q] <= data_in;
    end

    // TX FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst_in || (fcr_wr && data_in[2])) begin
            tx_wp_q <= '0; tx_rp_q <= '0; tx_cnt_q <= '0;
        end else begin
            if (tx_push) tx_wp_q <= tx_wp_q + 1'b1;
            if (tx_pop)  tx_rp_q <= tx_rp_q + 1'b1;
            case ({tx_push, tx_pop})
                2'b10:   tx_cnt_q <= tx_cnt_q + 1'b1;
                2'b01:   tx_cnt_q <= tx_cnt_q - 1'b1;
                default: tx_cnt_q <= tx_cnt_q;
            endcase
        end
    end

    // Transmitter
    tx_state_e  tx_state_q, tx_state_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [2:0] tx_bit_q, tx_bit_d, nbits_m1;
    logic [3:0] tx_tick_q, tx_tick_d;
    logic       tx_par_q, tx_par_d, txd, tx_line, tx_end;
    assign nbits_m1 = {1'b1, lcr_q[1:0]};
    assign tx_end   = baud_tick && tx_tick_q == 4'hF;

    // TX state register
    always_ff @(posedge clk) begin
        if (rst_in) begin
            tx_state_q <= TxIdle; tx_shift_q <= '0; tx_bit_q <= '0;
            tx_tick_q  <= '0;     tx_par_q   <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d; tx_shift_q <= tx_shift_d; tx_bit_q <= tx_bit_d;
            tx_tick_q  <= tx_tick_d;  tx_par_q   <= tx_par_d;
        end
    end

    // TX next state: start, data LSB-first, optional parity, 1 or 2 stop bits
    always_comb begin
        tx_state_d = tx_state_q;
        tx_shift_d = tx_shift_q;
        tx_bit_d   = tx_bit_q;
        tx_tick_d  = tx_tick_q + {3'b000, baud_tick};
        tx_par_d   = tx_par_q;
        tx_pop     = 1'b0;
        txd        = 1'b1;
        unique case (tx_state_q)
            TxIdle: begin
                tx_tick_d = '0;
                if (tx_cnt_q != '0) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = tx_mem[tx_rp_q];
                    tx_par_d   = par_calc(tx_mem[tx_rp_q], lcr_q[1:0], lcr_q[4], lcr_q[5]);
                    tx_state_d = TxStart;
                end
            end
            TxStart: begin
                txd = 1'b0;
                if (tx_end) begin tx_state_d = TxData; tx_bit_d = '0; end
            end
            TxData: begin
                txd = tx_shift_q[0];
                if (tx_end) begin
                    tx_shift_d = tx_shift_q >> 1;
                    tx_bit_d   = tx_bit_q + 3'd1;
                    if (tx_bit_q == nbits_m1) begin
                        tx_bit_d   = '0;
                        tx_state_d = lcr_q[3] ? TxParity : TxStop;
                    end
                end
            end
            TxParity: begin
                txd = tx_par_q;
                if (tx_end) begin tx_state_d = TxStop; tx_bit_d = '0; end
            end
            TxStop: begin
                if (tx_end) begin
                    if (tx_bit_q == 3'd0 && lcr_q[2]) begin
                        tx_bit_d = 3'd1;
                    end else if (tx_cnt_q != '0) begin
                        // Back-to-back: next byte starts straight after the stop bit.
                        tx_pop     = 1'b1;
                        tx_shift_d = tx_mem[tx_rp_q];
                        tx_par_d   = par_calc(tx_mem[tx_rp_q], lcr_q[1:0], lcr_q[4], lcr_q[5]);
                        tx_state_d = TxStart;
                    end else begin
                        tx_state_d = TxIdle;
                    end
                end
            end
            default: tx_state_d = TxIdle;
        endcase
    end

    assign tx_line = lcr_q[6] ? 1'b0 : txd;

    // Receiver input: synchronise the pad; loopback takes the internal TX line.
    logic [1:0] rx_sync_q;
    logic       rx_prev_q, rx_line;
    assign rx_line = mcr_q[4] ? tx_line : rx_sync_q[1];
    always_ff @(posedge clk) begin
        if (rst_in) begin
            rx_sync_q <= 2'b11; rx_prev_q <= 1'b1; tx_out_q <= 1'b1;
        end else begin
            rx_sync_q <= {rx_sync_q[0], rx_in};
            rx_prev_q <= rx_line;
            tx_out_q  <= mcr_q[4] ? 1'b1 : tx_line;
        end
    end

    // Receiver
    rx_state_e  rx_state_q, rx_state_d;
    logic [7:0] rx_shift_q, rx_shift_d, rx_data;
    logic [2:0] rx_bit_q, rx_bit_d;
    logic [3:0] rx_tick_q, rx_tick_d;
    logic       rx_pe_q, rx_pe_d, rx_zero_q, rx_zero_d, rx_sample;
    logic       rx_push, rx_full, rx_fe, rx_bi;
    assign rx_data   = rx_shift_q >> (2'd3 - lcr_q[1:0]);
    assign rx_sample = baud_tick && rx_tick_q == ((rx_state_q == RxStart) ? 4'd7 : 4'd15);

    // RX state register
    always_ff @(posedge clk) begin
        if (rst_in) begin
            rx_state_q <= RxIdle; rx_shift_q <= '0; rx_bit_q <= '0;
            rx_tick_q  <= '0;     rx_pe_q    <= 1'b0; rx_zero_q <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d; rx_shift_q <= rx_shift_d; rx_bit_q  <= rx_bit_d;
            rx_tick_q  <= rx_tick_d;  rx_pe_q    <= rx_pe_d;    rx_zero_q <= rx_zero_d;
        end
    end

    // RX next state: start confirmed at tick 8, then every bit sampled mid-bit
    always_comb begin
        rx_state_d = rx_state_q;
        rx_shift_d = rx_shift_q;
        rx_bit_d   = rx_bit_q;
        rx_tick_d  = rx_tick_q + {3'b000, baud_tick};
        rx_pe_d    = rx_pe_q;
        rx_zero_d  = rx_zero_q;
        rx_push    = 1'b0;
        rx_fe      = 1'b0;
        rx_bi      = 1'b0;
        unique case (rx_state_q)
            RxIdle: begin
                rx_tick_d = '0;
                if (rx_prev_q && !rx_line) rx_state_d = RxStart;
            end
            RxStart: begin
                if (rx_sample) begin
                    rx_tick_d  = '0;
                    rx_bit_d   = '0;
                    rx_pe_d    = 1'b0;
                    rx_zero_d  = 1'b1;
                    rx_state_d = rx_line ? RxIdle : RxData;
                end
            end
            RxData: begin
                if (rx_sample) begin
                    rx_shift_d = {rx_line, rx_shift_q[7:1]};
                    rx_zero_d  = rx_zero_q & ~rx_line;
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == nbits_m1) rx_state_d = lcr_q[3] ? RxParity : RxStop;
                end
            end
            RxParity: begin
                if (rx_sample) begin
                    rx_pe_d    = rx_line != par_calc(rx_data, lcr_q[1:0], lcr_q[4], lcr_q[5]);
                    rx_zero_d  = rx_zero_q & ~rx_line;
                    rx_state_d = RxStop;
                end
            end
            RxStop: begin
                if (rx_sample) begin
                    rx_push    = 1'b1;
                    rx_fe      = ~rx_line;
                    rx_bi      = rx_zero_q & ~rx_line;
                    rx_state_d = RxIdle;
                end
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    // RX FIFO carries a per-entry error flag for LSR[7]
    logic [7:0]    rx_mem  [FIFO_DEPTH];
    logic          rx_emem [FIFO_DEPTH];
    logic [PW-1:0] rx_wp_q, rx_rp_q;
    logic [CW-1:0] rx_cnt_q, trig_lvl;
    logic          rx_wr, rx_pop, rx_err_any;
    assign rx_full = rx_cnt_q == Full;
    assign rx_wr   = rx_push & ~rx_full;
    assign rx_pop  = rbr_rd && rx_cnt_q != '0;

    // RX FIFO storage
    always_ff @(posedge clk) begin
        if (rx_wr) begin
            rx_mem[rx_wp_q]  <= rx_data;
            rx_emem[rx_wp_q] <= rx_pe_q | rx_fe | rx_bi;
        end
    end

    // RX FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst_in || (fcr_wr && data_in[1])) begin
            rx_wp_q <= '0; rx_rp_q <= '0; rx_cnt_q <= '0;
        end else begin
            if (rx_wr)  rx_wp_q <= rx_wp_q + 1'b1;
            if (rx_pop) rx_rp_q <= rx_rp_q + 1'b1;
            case ({rx_wr, rx_pop})
                2'b10:   rx_cnt_q <= rx_cnt_q + 1'b1;
                2'b01:   rx_cnt_q <= rx_cnt_q - 1'b1;
                default: rx_cnt_q <= rx_cnt_q;
            endcase
        end
    end

    // Any occupied RX entry flagged with an error
    always_comb begin
        rx_err_any = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (CW'(i) < rx_cnt_q) rx_err_any = rx_err_any | rx_emem[rx_rp_q + PW'(i)];
        end
    end

    // Line status, interrupt sources and identification
    logic [7:0] lsr, rdata;
    logic [3:0] iir_id;
    always_comb begin
        case (trig_q)
            2'd0:    trig_lvl = CW'(1);
            2'd1:    trig_lvl = CW'(4);
            2'd2:    trig_lvl = CW'(8);
            default: trig_lvl = CW'(14);
        endcase
        lsr = {rx_err_any, tx_cnt_q == '0 && tx_state_q == TxIdle, tx_cnt_q == '0,
               bi_q, fe_q, pe_q, oe_q, rx_cnt_q != '0};
        if (ier_q[2] && (oe_q | pe_q | fe_q | bi_q)) iir_id = 4'h6;
        else if (ier_q[0] && rx_cnt_q >= trig_lvl)   iir_id = 4'h4;
        else if (ier_q[1] && thre_q)                 iir_id = 4'h2;
        else                                         iir_id = 4'h1;
    end
    assign int_out = ~iir_id[0];

    // Read data mux
    always_comb begin
        case (addr_in)
            3'd0:    rdata = dlab ? dll_q : (rx_cnt_q != '0 ? rx_mem[rx_rp_q] : rbr_q);
            3'd1:    rdata = dlab ? dlm_q : {4'h0, ier_q};
            3'd2:    rdata = {4'hC, iir_id};
            3'd3:    rdata = lcr_q;
            3'd4:    rdata = {3'b000, mcr_q};
            3'd5:    rdata = lsr;
            3'd7:    rdata = scr_q;
            default: rdata = 8'h00;
        endcase
    end

    // Bus acknowledge, registered read data and register writes
    always_ff @(posedge clk) begin
        if (rst_in) begin
            ack_q <= 1'b0; dout_q <= '0; ier_q <= '0; lcr_q <= 8'h03; mcr_q <= '0;
            scr_q <= '0; dll_q <= 8'h01; dlm_q <= '0; trig_q <= '0; rbr_q <= '0;
        end else begin
            ack_q <= req;
            if (req)    dout_q <= wr_enb_in ? 8'h00 : rdata;
            if (rx_pop) rbr_q  <= rx_mem[rx_rp_q];
            if (wr) begin
                case (addr_in)
                    3'd0: if (dlab) dll_q <= data_in;
                    3'd1: if (dlab) dlm_q <= data_in; else ier_q <= data_in[3:0];
                    3'd2: trig_q <= data_in[7:6];
                    3'd3: lcr_q  <= data_in;
                    3'd4: mcr_q  <= data_in[4:0];
                    3'd7: scr_q  <= data_in;
                    default: ;
                endcase
            end
        end
    end

    // Sticky line-status errors and THR-empty flag
    always_ff @(posedge clk) begin
        if (rst_in) begin
            oe_q <= 1'b0; pe_q <= 1'b0; fe_q <= 1'b0; bi_q <= 1'b0; thre_q <= 1'b0;
        end else begin
            if (lsr_rd) begin
                oe_q <= 1'b0; pe_q <= 1'b0; fe_q <= 1'b0; bi_q <= 1'b0;
            end
            if (rx_push) begin
                if (rx_full) oe_q <= 1'b1;
                if (rx_pe_q) pe_q <= 1'b1;
                if (rx_fe)   fe_q <= 1'b1;
                if (rx_bi)   bi_q <= 1'b1;
            end
            if (iir_rd || thr_wr)                            thre_q <= 1'b0;
            if (tx_pop && !tx_push && tx_cnt_q == CW'(1))    thre_q <= 1'b1;
        end
    end

    assign ack_out  = ack_q;
    assign data_out = dout_q;
    assign tx_out   = tx_out_q;

endmodule

// File: tb/tb_uart_modport.sv
// Directed bench for uart_modport: register-map vector table plus loopback,
// interrupt, overrun and parity-error sequences.
module tb_uart_modport;
    logic       clk = 1'b0;
    logic       rst_in = 1'b1;
    logic [2:0] addr_in = '0;
    logic [7:0] data_in = '0;
    logic [7:0] data_out;
    logic [3:0] sel_in = '0;
    logic       stb_in = 1'b0, cyc_in = 1'b0, wr_enb_in = 1'b0;
    logic       ack_out, int_out;
    logic       rx_in = 1'b1;
    logic       tx_out;

    int checks = 0;
    int errors = 0;

    uart_modport #(.FIFO_DEPTH(16)) dut (
        .clk(clk), .rst_in(rst_in), .addr_in(addr_in), .data_in(data_in),
        .data_out(data_out), .sel_in(sel_in), .stb_in(stb_in), .cyc_in(cyc_in),
        .wr_enb_in(wr_enb_in), .ack_out(ack_out), .int_out(int_out),
        .rx_in(rx_in), .tx_out(tx_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic [2:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp;
        string      name;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    // One bus access; checks the single-cycle ack pulse.
    task automatic bus(input logic wr, input logic [2:0] a, input logic [7:0] wd,
                       output logic [7:0] rd);
        @(negedge clk);
        stb_in = 1'b1; cyc_in = 1'b1; sel_in = 4'h1; wr_enb_in = wr; addr_in = a; data_in = wd;
        @(posedge clk); #1;
        chk("ack_high", {7'b0, ack_out}, 8'h01);
        rd = data_out;
        stb_in = 1'b0; cyc_in = 1'b0; sel_in = 4'h0; wr_enb_in = 1'b0;
        @(posedge clk); #1;
        chk("ack_low", {7'b0, ack_out}, 8'h00);
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [7:0] d);
        logic [7:0] dummy;
        bus(1'b1, a, d, dummy);
    endtask

    task automatic rd_chk(input string name, input logic [2:0] a, input logic [7:0] exp);
        logic [7:0] r;
        bus(1'b0, a, 8'h00, r);
        chk(name, r, exp);
    endtask

    task automatic send_bit(input logic b);
        rx_in = b;
        repeat (16) @(posedge clk);
    endtask

    initial begin
        logic [7:0] r;
        int         acks;
        logic       tx_low;
        logic [7:0] byte_v;

        vecs.push_back('{1'b0, 3'd0, 8'h00, 8'h00, "rst_rbr"});
        vecs.push_back('{1'b0, 3'd1, 8'h00, 8'h00, "rst_ier"});
        vecs.push_back('{1'b0, 3'd2, 8'h00, 8'hC1, "rst_iir"});
        vecs.push_back('{1'b0, 3'd3, 8'h00, 8'h03, "rst_lcr"});
        vecs.push_back('{1'b0, 3'd4, 8'h00, 8'h00, "rst_mcr"});
        vecs.push_back('{1'b0, 3'd5, 8'h00, 8'h60, "rst_lsr"});
        vecs.push_back('{1'b0, 3'd6, 8'h00, 8'h00, "rst_msr"});
        vecs.push_back('{1'b0, 3'd7, 8'h00, 8'h00, "rst_scr"});
        vecs.push_back('{1'b1, 3'd3, 8'h83, 8'h00, "lcr_dlab"});
        vecs.push_back('{1'b1, 3'd0, 8'h05, 8'h00, "dll_wr"});
        vecs.push_back('{1'b1, 3'd1, 8'h00, 8'h00, "dlm_wr"});
        vecs.push_back('{1'b0, 3'd0, 8'h00, 8'h05, "dll_rd"});
        vecs.push_back('{1'b0, 3'd1, 8'h00, 8'h00, "dlm_rd"});
        vecs.push_back('{1'b1, 3'd3, 8'h03, 8'h00, "lcr_wr"});
        vecs.push_back('{1'b0, 3'd3, 8'h00, 8'h03, "lcr_rd"});
        vecs.push_back('{1'b0, 3'd0, 8'h00, 8'h00, "rbr_empty"});
        vecs.push_back('{1'b1, 3'd3, 8'h83, 8'h00, "lcr_dlab2"});
        vecs.push_back('{1'b1, 3'd0, 8'h01, 8'h00, "dll_one"});
        vecs.push_back('{1'b1, 3'd3, 8'h03, 8'h00, "lcr_8n1"});
        vecs.push_back('{1'b1, 3'd7, 8'h5A, 8'h00, "scr_wr"});
        vecs.push_back('{1'b0, 3'd7, 8'h00, 8'h5A, "scr_rd"});
        vecs.push_back('{1'b1, 3'd5, 8'hFF, 8'h00, "lsr_wr_ro"});
        vecs.push_back('{1'b0, 3'd5, 8'h00, 8'h60, "lsr_ro"});
        vecs.push_back('{1'b1, 3'd6, 8'hFF, 8'h00, "msr_wr"});
        vecs.push_back('{1'b0, 3'd6, 8'h00, 8'h00, "msr_rd"});
        vecs.push_back('{1'b1, 3'd1, 8'hFF, 8'h00, "ier_wr"});
        vecs.push_back('{1'b0, 3'd1, 8'h00, 8'h0F, "ier_rd"});
        vecs.push_back('{1'b1, 3'd1, 8'h00, 8'h00, "ier_clr"});

        // Reset outputs, during reset and the cycle after release
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", {7'b0, ack_out}, 8'h00);
        chk("rst_dout", data_out, 8'h00);
        chk("rst_int", {7'b0, int_out}, 8'h00);
        chk("rst_tx", {7'b0, tx_out}, 8'h01);
        @(negedge clk);
        rst_in = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_tx", {7'b0, tx_out}, 8'h01);
        chk("post_rst_int", {7'b0, int_out}, 8'h00);

        for (int i = 0; i < vecs.size(); i++) begin
            bus(vecs[i].wr, vecs[i].addr, vecs[i].wdata, r);
            if (!vecs[i].wr) chk(vecs[i].name, r, vecs[i].exp);
        end

        // Held strobe: one ack every two cycles
        @(negedge clk);
        stb_in = 1'b1; cyc_in = 1'b1; sel_in = 4'h1; wr_enb_in = 1'b0; addr_in = 3'd7;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (ack_out) acks++;
        end
        stb_in = 1'b0; cyc_in = 1'b0; sel_in = 4'h0;
        chk("b2b_acks", 8'(acks), 8'd3);
        @(posedge clk); #1;

        // Loopback one byte
        wr_reg(3'd4, 8'h10);
        wr_reg(3'd0, 8'hA5);
        tx_low = 1'b0;
        repeat (180) begin
            @(posedge clk); #1;
            if (tx_out !== 1'b1) tx_low = 1'b1;
        end
        chk("loop_tx_idle", {7'b0, tx_low}, 8'h00);
        rd_chk("loop_lsr", 3'd5, 8'h61);
        rd_chk("loop_rbr", 3'd0, 8'hA5);
        rd_chk("loop_lsr_empty", 3'd5, 8'h60);

        // RX data interrupt
        wr_reg(3'd1, 8'h01);
        wr_reg(3'd0, 8'h3C);
        repeat (180) @(posedge clk);
        #1;
        chk("rx_int_on", {7'b0, int_out}, 8'h01);
        rd_chk("iir_rx", 3'd2, 8'hC4);
        rd_chk("rx_int_rbr", 3'd0, 8'h3C);
        chk("rx_int_off", {7'b0, int_out}, 8'h00);
        rd_chk("iir_none", 3'd2, 8'hC1);

        // Overrun: 17 bytes into a 16-entry RX FIFO
        wr_reg(3'd1, 8'h05);
        for (int i = 0; i < 17; i++) wr_reg(3'd0, 8'(8'h10 + i));
        repeat (3000) @(posedge clk);
        #1;
        chk("ovr_int", {7'b0, int_out}, 8'h01);
        rd_chk("iir_ls", 3'd2, 8'hC6);
        rd_chk("ovr_lsr", 3'd5, 8'h63);
        rd_chk("ovr_lsr_clr", 3'd5, 8'h61);
        rd_chk("iir_after_ls", 3'd2, 8'hC4);
        for (int i = 0; i < 16; i++) begin
            byte_v = 8'(8'h10 + i);
            rd_chk("ovr_data", 3'd0, byte_v);
        end
        rd_chk("ovr_drained", 3'd5, 8'h60);
        wr_reg(3'd1, 8'h00);

        // External line, 8E1, 0x55 with wrong parity bit (even parity would be 0)
        wr_reg(3'd4, 8'h00);
        wr_reg(3'd3, 8'h1B);
        @(posedge clk); #1;
        chk("ext_tx_idle", {7'b0, tx_out}, 8'h01);
        byte_v = 8'h55;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(byte_v[i]);
        send_bit(1'b1);
        send_bit(1'b1);
        repeat (20) @(posedge clk);
        rd_chk("par_lsr", 3'd5, 8'hE5);
        rd_chk("par_rbr", 3'd0, 8'h55);
        rd_chk("par_lsr_clr", 3'd5, 8'h60);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time limit so the run always ends
    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
